// File: rtl/sram_arbiter_pkg.sv
`default_nettype none
// sram_arbiter_pkg: shared state, owner, grant and size encodings for the SRAM arbiter.
// Revision 1.0
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  localparam int GNT_INST = 0;
  localparam int GNT_DATA = 1;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage
`default_nettype wire

// File: rtl/sram_arb_grant.sv
`default_nettype none
// sram_arb_grant: one-hot grant selection; SRAM_ARB_ROUND_ROBIN_EN selects alternating priority.
// Revision 1.0
module sram_arb_grant
  import sram_arbiter_pkg::*;
(
  input  logic       inst_req,
  input  logic       data_req,
  input  owner_t     last_grant,
  output logic [1:0] grant
);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  always_comb begin
    grant = '0;
    if (inst_req && data_req) begin
      // Favour whichever requester did not win the previous grant.
      if (last_grant == OWN_DATA) grant[GNT_INST] = 1'b1;
      else                        grant[GNT_DATA] = 1'b1;
    end else begin
      grant[GNT_INST] = inst_req;
      grant[GNT_DATA] = data_req;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant = '0;
    grant[GNT_DATA] = data_req;
    grant[GNT_INST] = inst_req & ~data_req;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// sram_arbiter: two-requester arbiter onto a single SRAM-like bus, one outstanding transaction.
// Revision 1.0 -- optional feature macro: SRAM_ARB_ROUND_ROBIN_EN
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              stallreq_for_bus
);

  state_t     state, state_next;
  owner_t     owner, last_owner;
  logic [1:0] grant;
  logic       done;

  sram_arb_grant u_grant (
    .inst_req   (inst_req),
    .data_req   (data_req),
    .last_grant (last_owner),
    .grant      (grant)
  );

  always_comb begin
    state_next   = state;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    bus_req      = 1'b0;
    done         = 1'b0;
    case (state)
      ST_IDLE: begin
        inst_addr_ok = grant[GNT_INST];
        data_addr_ok = grant[GNT_DATA];
        if (grant != 2'b00) state_next = ST_ADDR;
      end
      ST_ADDR: begin
        bus_req = 1'b1;
        if (bus_addr_ok) begin
          // A slave may accept and answer in the same cycle.
          done       = bus_data_ok;
          state_next = bus_data_ok ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus_data_ok) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign stallreq_for_bus = (data_req & ~data_addr_ok) |
                            ((state != ST_IDLE) & (owner == OWN_DATA));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      owner        <= OWN_INST;
      bus_wr       <= 1'b0;
      bus_size     <= '0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      inst_rdata   <= '0;
      data_rdata   <= '0;
    end else begin
      state        <= state_next;
      inst_data_ok <= done & (owner == OWN_INST);
      data_data_ok <= done & (owner == OWN_DATA);
      if (data_addr_ok) begin
        owner     <= OWN_DATA;
        bus_wr    <= data_wr;
        bus_size  <= data_size;
        bus_addr  <= data_addr;
        bus_wdata <= data_wdata;
      end else if (inst_addr_ok) begin
        owner     <= OWN_INST;
        bus_wr    <= 1'b0;
        bus_size  <= SIZE_WORD;
        bus_addr  <= inst_addr;
        bus_wdata <= '0;
      end
      if (done && owner == OWN_INST)           inst_rdata <= bus_rdata;
      if (done && owner == OWN_DATA && !bus_wr) data_rdata <= bus_rdata;
    end
  end

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst)               last_owner <= OWN_INST;
    else if (data_addr_ok) last_owner <= OWN_DATA;
    else if (inst_addr_ok) last_owner <= OWN_INST;
  end
`else
  assign last_owner = OWN_INST;
`endif

endmodule
`default_nettype wire
